// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: orders memory freeze, branch redirect,
// load-use stall and fetch handshaking into one priority decision per cycle.
// Two flags persist between cycles: ost (a fetch is outstanding) and drop
// (the next fetch response belongs to a squashed path).
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
module pipeline_hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    input  logic        imem_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_ex_rd_i,
    input  logic        id_ex_mem_read_i,
    input  logic        branch_taken_i,
    input  logic        dmem_busy_i,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_write_o,
    output logic        id_ex_flush_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic [1:0]  state_o
);
    // Handshake: imem_req_o is a one-cycle request at the current PC; the
    // memory then raises imem_valid_i and holds it (with its data) until a
    // cycle in which this block consumes it (branch, write or drop case).

    localparam logic [1:0] ST_RUN        = 2'b00;
    localparam logic [1:0] ST_FETCH_WAIT = 2'b01;
    localparam logic [1:0] ST_DRAIN      = 2'b10;
    localparam logic [1:0] ST_MEM_WAIT   = 2'b11;

    logic r_ost;
    logic r_drop;
    logic r_busy_q;

    logic w_load_use;
    logic w_consume;
    logic w_set_drop;
    logic w_clr_drop;
    logic w_stall_evt;
    logic w_flush_evt;

    assign w_load_use = id_ex_mem_read_i && (id_ex_rd_i != 5'd0) &&
                        ((id_ex_rd_i == id_rs1_i) || (id_ex_rd_i == id_rs2_i));

    // Priority decision: first matching case drives the control outputs.
    always_comb begin
        imem_req_o    = 1'b0;
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_write_o = 1'b0;
        id_ex_flush_o = 1'b0;
        w_consume     = 1'b0;
        w_set_drop    = 1'b0;
        w_clr_drop    = 1'b0;
        w_stall_evt   = 1'b0;
        w_flush_evt   = 1'b0;
        if (!rst_ni) begin
            // everything held low while in reset
        end else if (dmem_busy_i) begin
            // freeze: nothing moves, pending response stays pending
            w_stall_evt = 1'b1;
        end else if (branch_taken_i) begin
            pc_write_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            id_ex_write_o = 1'b1;
            w_flush_evt   = 1'b1;
            if (imem_valid_i) begin
                // wrong-path response discarded; nothing else is in flight
                w_consume  = 1'b1;
                w_clr_drop = 1'b1;
            end else if (r_ost) begin
                w_set_drop = 1'b1;
            end
        end else if (w_load_use) begin
            id_ex_flush_o = 1'b1;
            id_ex_write_o = 1'b1;
            w_stall_evt   = 1'b1;
        end else if (imem_valid_i && !r_drop) begin
            if_id_write_o = 1'b1;
            imem_req_o    = 1'b1;
            pc_write_o    = 1'b1;
            id_ex_write_o = 1'b1;
            w_consume     = 1'b1;
        end else if (imem_valid_i) begin
            if_id_flush_o = 1'b1;
            imem_req_o    = 1'b1;
            pc_write_o    = 1'b1;
            id_ex_write_o = 1'b1;
            w_consume     = 1'b1;
            w_clr_drop    = 1'b1;
        end else if (r_ost) begin
            if_id_flush_o = 1'b1;
            id_ex_write_o = 1'b1;
        end else begin
            imem_req_o    = 1'b1;
            pc_write_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_write_o = 1'b1;
        end
    end

    // Outstanding/drop flags and last-cycle memory-busy history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ost    <= 1'b0;
            r_drop   <= 1'b0;
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= dmem_busy_i;
            // a new request wins over a consume in the same cycle
            if (imem_req_o) begin
                r_ost <= 1'b1;
            end else if (w_consume) begin
                r_ost <= 1'b0;
            end
            if (w_set_drop) begin
                r_drop <= 1'b1;
            end else if (w_clr_drop) begin
                r_drop <= 1'b0;
            end
        end
    end

    // Debug state derived from the flags and the busy history.
    always_comb begin
        state_o = ST_RUN;
        if (r_busy_q) begin
            state_o = ST_MEM_WAIT;
        end else if (r_ost && r_drop) begin
            state_o = ST_DRAIN;
        end else if (r_ost) begin
            state_o = ST_FETCH_WAIT;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Event counters: stall = freeze or load-use, flush = branch redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_evt) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_evt) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_stall_evt ^ w_flush_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: instruction-memory responder, reference
// model of the priority cases, per-cycle compare and directed checkpoints.
// Build with +define+HAZARD_PERF_CNT_EN to cover the event counters.
module tb_pipeline_hazard_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       imem_req_o;
  logic       imem_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_ex_rd_i;
  logic       id_ex_mem_read_i, branch_taken_i, dmem_busy_i;
  logic       pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_flush_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .imem_req_o       (imem_req_o),
    .imem_valid_i     (imem_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_ex_rd_i       (id_ex_rd_i),
    .id_ex_mem_read_i (id_ex_mem_read_i),
    .branch_taken_i   (branch_taken_i),
    .dmem_busy_i      (dmem_busy_i),
    .pc_write_o       (pc_write_o),
    .if_id_write_o    (if_id_write_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_write_o    (id_ex_write_o),
    .id_ex_flush_o    (id_ex_flush_o),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o),
`endif
    .state_o          (state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // case number 1..7 from the priority list
  function automatic int classify(input logic busy, br, mr, input logic [4:0] rd, rs1, rs2,
                                  input logic valid, ost, drop);
    if (busy) return 1;
    if (br) return 2;
    if (mr && rd != 5'd0 && (rd == rs1 || rd == rs2)) return 3;
    if (valid && !drop) return 4;
    if (valid) return 5;
    if (ost) return 6;
    return 7;
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, imem_req}
  function automatic logic [5:0] outs_for(input int c);
    case (c)
      1: return 6'b000000;
      2: return 6'b101110;
      3: return 6'b000110;
      4: return 6'b110101;
      5: return 6'b101101;
      6: return 6'b001100;
      default: return 6'b101101;
    endcase
  endfunction

  logic        m_ost, m_drop, m_busy_q;
  logic        mem_has;
  int          mem_cnt;
  int          mem_lat = 1;
  logic [31:0] m_stall, m_flush;
  int          u_case;
  logic [5:0]  u_o;
  logic        u_cons;

  assign imem_valid_i = mem_has && (mem_cnt == 0);

  // model state + instruction memory; a reset loses any pending response
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_ost <= 1'b0; m_drop <= 1'b0; m_busy_q <= 1'b0;
      mem_has <= 1'b0; mem_cnt <= 0;
      m_stall <= 32'd0; m_flush <= 32'd0;
    end else begin
      u_case = classify(dmem_busy_i, branch_taken_i, id_ex_mem_read_i, id_ex_rd_i,
                        id_rs1_i, id_rs2_i, imem_valid_i, m_ost, m_drop);
      u_o    = outs_for(u_case);
      u_cons = imem_valid_i && (u_case == 2 || u_case == 4 || u_case == 5);
      m_busy_q <= dmem_busy_i;
      m_ost <= u_o[0] ? 1'b1 : (u_cons ? 1'b0 : m_ost);
      if (u_case == 2) m_drop <= imem_valid_i ? 1'b0 : (m_ost ? 1'b1 : m_drop);
      else if (u_case == 5) m_drop <= 1'b0;
      if (u_o[0]) begin
        mem_has <= 1'b1; mem_cnt <= mem_lat - 1;
      end else if (u_cons) begin
        mem_has <= 1'b0;
      end else if (mem_has && mem_cnt != 0) begin
        mem_cnt <= mem_cnt - 1;
      end
      if (u_case == 1 || u_case == 3) m_stall <= m_stall + 32'd1;
      if (u_case == 2) m_flush <= m_flush + 32'd1;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [5:0] act_o;
  assign act_o = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_flush_o, imem_req_o};

  always @(negedge clk_i) begin
    logic [5:0] e_o;
    logic [1:0] e_st;
    if (!rst_ni) begin
      e_o = 6'b0; e_st = 2'b00;
    end else begin
      e_o  = outs_for(classify(dmem_busy_i, branch_taken_i, id_ex_mem_read_i, id_ex_rd_i,
                               id_rs1_i, id_rs2_i, imem_valid_i, m_ost, m_drop));
      e_st = m_busy_q ? 2'b11 : (m_ost && m_drop) ? 2'b10 : m_ost ? 2'b01 : 2'b00;
    end
    checks++;
    if (act_o !== e_o) begin
      errors++;
      $display("FAIL outs t=%0t actual=%b expected=%b", $time, act_o, e_o);
    end
    checks++;
    if (state_o !== e_st) begin
      errors++;
      $display("FAIL state t=%0t actual=%b expected=%b", $time, state_o, e_st);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
      errors++;
      $display("FAIL counters t=%0t actual=%0d/%0d expected=%0d/%0d",
               $time, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
    end
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic busy, br, mr, input logic [4:0] rd, rs1, rs2);
    dmem_busy_i = busy; branch_taken_i = br; id_ex_mem_read_i = mr;
    id_ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0);
    repeat (3) next_cycle();
    pin("rst_outs", {26'd0, act_o}, 32'd0);
    pin("rst_state", {30'd0, state_o}, 32'd0);

    // first cycle after release: fetch request with bubble
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("first_req", {31'd0, imem_req_o}, 32'd1);
    pin("first_flush", {31'd0, if_id_flush_o}, 32'd1);
    next_cycle(); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("resp_write", {30'd0, if_id_write_o, imem_req_o}, 32'd3);

    // load-use on rs2, then rd=x0 which must not stall
    next_cycle(); drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5);
    pin("lu_stall", {29'd0, pc_write_o, if_id_write_o, id_ex_flush_o}, 32'b001);
    mem_lat = 3;
    next_cycle(); drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    pin("x0_nostall", {30'd0, if_id_write_o, id_ex_flush_o}, 32'b10);

    // branch while fetch outstanding: drain the wrong-path response
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("br_outs", {29'd0, pc_write_o, if_id_flush_o, id_ex_flush_o}, 32'b111);
    pin("br_state", {30'd0, state_o}, 32'b01);
    next_cycle(); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("drain_state", {30'd0, state_o}, 32'b10);
    mem_lat = 1;
    next_cycle(); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("drop_resp", {29'd0, if_id_flush_o, if_id_write_o, imem_req_o}, 32'b101);

    // memory freeze with a response pending
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("after_drop_state", {30'd0, state_o}, 32'b01);
    pin("busy1_outs", {26'd0, act_o}, 32'd0);
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("busy2_state", {30'd0, state_o}, 32'b11);
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("busy3_outs", {26'd0, act_o}, 32'd0);
    next_cycle(); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pin("post_busy", {29'd0, if_id_write_o, state_o}, 32'b111);

    // branch and load-use together: branch wins
    next_cycle(); drive(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0);
    pin("br_wins", {29'd0, pc_write_o, if_id_flush_o, id_ex_flush_o}, 32'b111);

    // mixed traffic checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      if (i % 16 == 0) mem_lat = $urandom_range(1, 4);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    // reset in mid-operation, then two load-use stalls and one branch
    next_cycle(); rst_ni = 1'b0; mem_lat = 1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    next_cycle(); rst_ni = 1'b1; #1;
    pin("rerst_req", {31'd0, imem_req_o}, 32'd1);
    next_cycle(); drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0);
    next_cycle(); drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 5'd4);
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    next_cycle(); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
`ifdef HAZARD_PERF_CNT_EN
    pin("stall_cnt", stall_cnt_o, 32'd2);
    pin("flush_cnt", flush_cnt_o, 32'd1);
`endif

    repeat (3) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
